// File: rtl/output_layer_scheduler.sv
// ---------------------------------------------------------------------------
// output_layer_scheduler
//
// Runs one inference window over a bank of N_OUT serial accumulator output
// neurons. The window opens when this block releases the shared neuron reset
// and closes on the first cycle any neuron fires, or when the RUN-cycle
// budget is exhausted. The winning class, the decision latency and a timeout
// flag are then offered over a valid/ready handshake.
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-low reset
//   start          request a new window (sampled in IDLE only)
//   abort          cancel the running window (sampled in RUN only)
//   neuron_fire    per-neuron fire flags, level
//   neuron_rst_n   registered active-low reset to all output neurons
//   busy           high while a window is running or a result is pending
//   result_valid   result available
//   result_ready   consumer accepts the result
//   result_class   winning neuron index (lowest index wins ties)
//   result_cycles  RUN cycles until the decision (MAX_CYCLES on timeout)
//   result_timeout no neuron fired within the budget
// ---------------------------------------------------------------------------
module output_layer_scheduler #(
  parameter  int N_OUT      = 10,
  parameter  int MAX_CYCLES = 2048,
  localparam int CW         = $clog2(N_OUT),
  localparam int TW         = $clog2(MAX_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] neuron_fire,
  output logic             neuron_rst_n,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CW-1:0]    result_class,
  output logic [TW-1:0]    result_cycles,
  output logic             result_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [TW-1:0] LAST_CNT = TW'(MAX_CYCLES - 1);
  localparam logic [TW-1:0] BUDGET   = TW'(MAX_CYCLES);

  state_t          state, state_nxt;
  logic [TW-1:0]   cnt, cnt_nxt;
  logic            rst_n_nxt, busy_nxt, valid_nxt, timeout_nxt;
  logic [CW-1:0]   class_nxt;
  logic [TW-1:0]   cycles_nxt;
  logic [CW-1:0]   fire_idx;

  // Fixed-priority encoder: scanning from the top down lets the lowest set
  // index overwrite any higher one, so bit 0 has the highest priority.
  always_comb begin
    fire_idx = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (neuron_fire[i]) fire_idx = CW'(i);
    end
  end

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here become visible on the same edge as the state change.
  // Defaults hold everything, which keeps the result stable in REPORT and
  // leaves it untouched on an abort.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rst_n_nxt   = neuron_rst_n;
    busy_nxt    = busy;
    valid_nxt   = result_valid;
    class_nxt   = result_class;
    cycles_nxt  = result_cycles;
    timeout_nxt = result_timeout;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          rst_n_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          rst_n_nxt = 1'b0;
          busy_nxt  = 1'b0;
        end else if (|neuron_fire) begin
          // A fire on the last budget cycle still counts as a fire.
          state_nxt   = REPORT;
          class_nxt   = fire_idx;
          cycles_nxt  = cnt;
          timeout_nxt = 1'b0;
          valid_nxt   = 1'b1;
          rst_n_nxt   = 1'b0;
        end else if (cnt == LAST_CNT) begin
          state_nxt   = REPORT;
          class_nxt   = '0;
          cycles_nxt  = BUDGET;
          timeout_nxt = 1'b1;
          valid_nxt   = 1'b1;
          rst_n_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end

      REPORT: begin
        if (result_valid && result_ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
        rst_n_nxt = 1'b0;
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous so a window can be
  // killed mid-flight and any pending result is discarded immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      neuron_rst_n   <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_class   <= '0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      neuron_rst_n   <= rst_n_nxt;
      busy           <= busy_nxt;
      result_valid   <= valid_nxt;
      result_class   <= class_nxt;
      result_cycles  <= cycles_nxt;
      result_timeout <= timeout_nxt;
    end
  end

endmodule
